// File: rtl/sr04_pkg.sv
// rtl/sr04_pkg.sv - shared state encoding, default timing constants and helpers for the SR04 controller
package sr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEAS,
    DIV,
    HOLD
  } state_t;

  localparam int unsigned TRIG_US_DEF    = 10;
  localparam int unsigned TIMEOUT_US_DEF = 30000;
  localparam int unsigned PERIOD_US_DEF  = 60000;
  localparam int unsigned US_PER_CM_DEF  = 58;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sr04_div.sv
// rtl/sr04_div.sv - sequential subtract divider, one subtraction per cycle, truncating quotient
module sr04_div
  import sr04_pkg::*;
#(
  parameter int unsigned DIVISOR = US_PER_CM_DEF
) (
  input  logic        clk_1m,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  output logic        done,
  output logic [9:0]  quotient
);

  localparam logic [15:0] DIV16 = 16'(DIVISOR);

  logic [15:0] rem;
  logic        running;

  // done is asserted in the cycle the remainder drops below the divisor, with quotient final
  assign done = running && (rem < DIV16);

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      running  <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      rem      <= dividend;
      quotient <= '0;
      running  <= 1'b1;
    end else if (running) begin
      if (rem >= DIV16) begin
        rem <= rem - DIV16;
        if (quotient != 10'h3FF) quotient <= quotient + 10'd1;
      end else begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sr04_ctrl.sv
// rtl/sr04_ctrl.sv - HC-SR04 ultrasonic ranger controller: trigger, echo timing, distance in cm
module sr04_ctrl
  import sr04_pkg::*;
#(
  parameter int unsigned TRIG_US    = TRIG_US_DEF,
  parameter int unsigned TIMEOUT_US = TIMEOUT_US_DEF,
  parameter int unsigned PERIOD_US  = PERIOD_US_DEF,
  parameter int unsigned US_PER_CM  = US_PER_CM_DEF
) (
  input  logic       clk_1m,
  input  logic       rst_n,
  input  logic       start,
  input  logic       auto_en,
  input  logic       s1_echo,
  output logic       s1_trig,
  output logic [9:0] dist_cm,
  output logic       dist_vld,
  output logic       err_to,
  output logic       busy
);

  localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_US - 1);
  localparam logic [15:0] PER_LAST  = 16'(PERIOD_US - 1);

  state_t      state;
  logic        echo_m, echo_s, echo_d;
  logic [15:0] w_cnt, per_cnt, width;
  logic        echo_rise, echo_fall, div_start, div_done;
  logic [9:0]  div_q;

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;
  assign div_start = (state == MEAS) && echo_fall;
  assign busy      = (state != IDLE);
  // the rise cycle itself is spent in WAIT_RISE, so the echo width is one more than w_cnt
  assign width     = sat_inc16(w_cnt);

  sr04_div #(.DIVISOR(US_PER_CM)) u_div (
    .clk_1m   (clk_1m),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (width),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      echo_m   <= 1'b0;
      echo_s   <= 1'b0;
      echo_d   <= 1'b0;
      w_cnt    <= '0;
      per_cnt  <= '0;
      s1_trig  <= 1'b0;
      dist_cm  <= '0;
      dist_vld <= 1'b0;
      err_to   <= 1'b0;
    end else begin
      echo_m   <= s1_echo;
      echo_s   <= echo_m;
      echo_d   <= echo_s;
      dist_vld <= 1'b0;
      err_to   <= 1'b0;
      if (state != IDLE) per_cnt <= sat_inc16(per_cnt);
      case (state)
        IDLE: begin
          if (start || auto_en) begin
            state   <= TRIG;
            per_cnt <= '0;
            w_cnt   <= '0;
            s1_trig <= 1'b1;
          end
        end
        TRIG: begin
          if (w_cnt >= TRIG_LAST) begin
            s1_trig <= 1'b0;
            w_cnt   <= '0;
            state   <= WAIT_RISE;
          end else begin
            w_cnt <= w_cnt + 16'd1;
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            w_cnt <= '0;
            state <= MEAS;
          end else if (w_cnt >= TO_LAST) begin
            err_to <= 1'b1;
            state  <= HOLD;
          end else begin
            w_cnt <= sat_inc16(w_cnt);
          end
        end
        MEAS: begin
          if (echo_fall) begin
            state <= DIV;
          end else if (echo_s) begin
            if (w_cnt >= TO_LAST) begin
              err_to <= 1'b1;
              state  <= HOLD;
            end else begin
              w_cnt <= sat_inc16(w_cnt);
            end
          end
        end
        DIV: begin
          if (div_done) begin
            dist_cm  <= div_q;
            dist_vld <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (per_cnt >= PER_LAST) begin
            if (auto_en) begin
              state   <= TRIG;
              per_cnt <= '0;
              w_cnt   <= '0;
              s1_trig <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr04_ctrl.sv
// tb/tb_sr04_ctrl.sv - self-checking bench for sr04_ctrl against a behavioural echo/distance model
`timescale 1ns/1ps
module tb_sr04_ctrl;

  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 1500;
  localparam int PERIOD_US  = 2500;
  localparam int US_PER_CM  = 58;

  logic       clk_1m = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       s1_echo = 1'b0;
  logic       s1_trig, dist_vld, err_to, busy;
  logic [9:0] dist_cm;

  always #500 clk_1m = ~clk_1m;

  sr04_ctrl #(
    .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US), .PERIOD_US(PERIOD_US), .US_PER_CM(US_PER_CM)
  ) dut (
    .clk_1m(clk_1m), .rst_n(rst_n), .start(start), .auto_en(auto_en), .s1_echo(s1_echo),
    .s1_trig(s1_trig), .dist_cm(dist_cm), .dist_vld(dist_vld), .err_to(err_to), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic trig_q = 1'b0;
  int trig_len = 0, last_trig_len = 0, trig_fall = 0;
  int rises[$];
  int vld_vals[$];
  int vld_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = -1;
  int echo_delay = 200, echo_width = 0, echo_on = -1, echo_off = -1;
  logic echo_stuck = 1'b0;
  logic rand_start = 1'b0;
  int last_dist = 0;

  // one clock of bench time: observe outputs, then drive the echo the sensor model wants
  task automatic tick();
    @(negedge clk_1m);
    cyc++;
    if (s1_trig) trig_len++;
    if (s1_trig && !trig_q) rises.push_back(cyc);
    if (!s1_trig && trig_q) begin
      last_trig_len = trig_len;
      trig_len = 0;
      trig_fall = cyc;
      if (echo_width > 0) begin
        echo_on  = cyc + echo_delay;
        echo_off = echo_on + echo_width;
      end
    end
    trig_q = s1_trig;
    if (dist_vld) begin
      vld_cnt++;
      vld_vals.push_back(int'(dist_cm));
    end
    if (err_to) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (dist_vld && err_to) both_cnt++;
    s1_echo = echo_stuck || (cyc >= echo_on && cyc < echo_off);
    if (rand_start) start = ($urandom_range(0, 49) == 0);
  endtask

  task automatic clear_stats();
    rises.delete();
    vld_vals.delete();
    vld_cnt = 0;
    err_cnt = 0;
    both_cnt = 0;
    err_cyc = -1;
  endtask

  task automatic run_single(input string name, input int delay, input int width);
    int   busy_low;
    bit   done_ok;
    bit   measured;
    int   exp_cm;
    echo_delay = delay;
    echo_width = width;
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    done_ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD_US; i++) begin
      if (!busy) begin
        done_ok = 1'b1;
        break;
      end
      tick();
    end
    busy_low = cyc;
    measured = (width > 0) && (width <= TIMEOUT_US);
    exp_cm = width / US_PER_CM;
    if (measured) last_dist = exp_cm;

    checks++;
    if (!done_ok) begin
      failures++;
      $display("FAIL %s_busy_timeout: busy=%0b required 0 within %0d cycles", name, busy, 2 * PERIOD_US);
    end
    checks++;
    if (rises.size() != 1 || last_trig_len != TRIG_US) begin
      failures++;
      $display("FAIL %s_trig: rises=%0d width=%0d required 1 and %0d", name, rises.size(), last_trig_len, TRIG_US);
    end
    if (rises.size() > 0) begin
      checks++;
      if (busy_low - rises[0] != PERIOD_US) begin
        failures++;
        $display("FAIL %s_busy_len: got %0d required %0d", name, busy_low - rises[0], PERIOD_US);
      end
    end
    checks++;
    if (measured) begin
      if (vld_cnt != 1 || err_cnt != 0 || vld_vals.size() != 1 || vld_vals[0] != exp_cm) begin
        failures++;
        $display("FAIL %s_dist: vld=%0d err=%0d cm=%0d required vld=1 err=0 cm=%0d", name, vld_cnt, err_cnt, int'(dist_cm), exp_cm);
      end
    end else begin
      if (vld_cnt != 0 || err_cnt != 1) begin
        failures++;
        $display("FAIL %s_timeout: vld=%0d err=%0d required vld=0 err=1", name, vld_cnt, err_cnt);
      end
    end
    if (width == 0) begin
      checks++;
      if (err_cyc - trig_fall != TIMEOUT_US) begin
        failures++;
        $display("FAIL %s_err_time: got %0d required %0d", name, err_cyc - trig_fall, TIMEOUT_US);
      end
    end
    checks++;
    if (int'(dist_cm) != last_dist || both_cnt != 0) begin
      failures++;
      $display("FAIL %s_hold: cm=%0d both=%0d required cm=%0d both=0", name, int'(dist_cm), both_cnt, last_dist);
    end
    echo_width = 0;
    echo_on = -1;
    echo_off = -1;
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) tick();
    checks++;
    if (s1_trig !== 1'b0 || dist_cm !== 10'd0 || dist_vld !== 1'b0 || err_to !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: trig=%0b cm=%0d vld=%0b err=%0b busy=%0b required all 0", s1_trig, dist_cm, dist_vld, err_to, busy);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || s1_trig !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%0b trig=%0b required 0 0", busy, s1_trig);
    end
  endtask

  task automatic test_basic();
    run_single("basic_580", 200, 580);
  endtask

  task automatic test_widths();
    run_single("w57", 50, 57);
    run_single("w_max", 100, TIMEOUT_US);
    run_single("w_over", 100, TIMEOUT_US + 1);
    run_single("w1160", 30, 1160);
  endtask

  task automatic test_no_echo();
    run_single("no_echo", 0, 0);
  endtask

  task automatic test_stuck_high();
    echo_stuck = 1'b1;
    repeat (6) tick();
    run_single("stuck_high", 0, 0);
    echo_stuck = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      run_single("rand", int'($urandom_range(5, 300)), int'($urandom_range(1, TIMEOUT_US + 300)));
    end
  endtask

  task automatic test_auto();
    int busy_low;
    bit ok;
    clear_stats();
    echo_delay = 200;
    echo_width = 1160;
    auto_en = 1'b1;
    rand_start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4 * PERIOD_US; i++) begin
      tick();
      if (rises.size() >= 3) begin
        if (cyc >= rises[2] + 1500) begin
          ok = 1'b1;
          break;
        end
      end
    end
    auto_en = 1'b0;
    rand_start = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2 * PERIOD_US && busy; i++) tick();
    busy_low = cyc;
    checks++;
    if (!ok || busy || rises.size() != 3) begin
      failures++;
      $display("FAIL auto_triggers: rises=%0d busy=%0b required 3 rises then idle", rises.size(), busy);
    end
    for (int i = 1; i < rises.size(); i++) begin
      checks++;
      if (rises[i] - rises[i-1] != PERIOD_US) begin
        failures++;
        $display("FAIL auto_period: got %0d required %0d", rises[i] - rises[i-1], PERIOD_US);
      end
    end
    checks++;
    if (vld_cnt != 3 || err_cnt != 0 || both_cnt != 0) begin
      failures++;
      $display("FAIL auto_counts: vld=%0d err=%0d both=%0d required 3 0 0", vld_cnt, err_cnt, both_cnt);
    end
    foreach (vld_vals[i]) begin
      checks++;
      if (vld_vals[i] != 1160 / US_PER_CM) begin
        failures++;
        $display("FAIL auto_dist: got %0d required %0d", vld_vals[i], 1160 / US_PER_CM);
      end
    end
    if (rises.size() == 3) begin
      checks++;
      if (busy_low - rises[2] != PERIOD_US) begin
        failures++;
        $display("FAIL auto_stop: got %0d required %0d", busy_low - rises[2], PERIOD_US);
      end
    end
    last_dist = 1160 / US_PER_CM;
    echo_width = 0;
    echo_on = -1;
    echo_off = -1;
    repeat (4) tick();
  endtask

  task automatic test_reset_trig();
    clear_stats();
    echo_width = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (s1_trig !== 1'b0 || busy !== 1'b0 || dist_cm !== 10'd0) begin
      failures++;
      $display("FAIL rst_trig_async: trig=%0b busy=%0b cm=%0d required 0 0 0", s1_trig, busy, dist_cm);
    end
    repeat (3) tick();
    checks++;
    if (dist_vld !== 1'b0 || err_to !== 1'b0 || s1_trig !== 1'b0) begin
      failures++;
      $display("FAIL rst_trig_hold: vld=%0b err=%0b trig=%0b required 0", dist_vld, err_to, s1_trig);
    end
    rst_n = 1'b1;
    last_dist = 0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_trig_idle: busy=%0b required 0", busy);
    end
    run_single("after_trig_rst", 150, 870);
  endtask

  task automatic test_reset_meas();
    clear_stats();
    echo_delay = 100;
    echo_width = 1160;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (TRIG_US + 700) tick();
    checks++;
    if (int'(dist_cm) != last_dist || !busy) begin
      failures++;
      $display("FAIL rst_meas_pre: cm=%0d busy=%0b required %0d 1", int'(dist_cm), busy, last_dist);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (s1_trig !== 1'b0 || busy !== 1'b0 || dist_cm !== 10'd0 || dist_vld !== 1'b0 || err_to !== 1'b0) begin
      failures++;
      $display("FAIL rst_meas_async: trig=%0b busy=%0b cm=%0d vld=%0b err=%0b required all 0", s1_trig, busy, dist_cm, dist_vld, err_to);
    end
    echo_width = 0;
    echo_on = -1;
    echo_off = -1;
    repeat (3) tick();
    rst_n = 1'b1;
    last_dist = 0;
    repeat (5) tick();
    run_single("after_meas_rst", 100, 1739);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_widths();
    test_no_echo();
    test_stuck_high();
    test_random();
    test_auto();
    test_reset_trig();
    test_reset_meas();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
